// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared forwarding-select codes, mult/div state type and helpers.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Register 0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic       wr_en,
                                     input logic [4:0] dst);
    return wr_en && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wr_en_m,
                                         input logic [4:0] wr_reg_m,
                                         input logic       wr_en_w,
                                         input logic [4:0] wr_reg_w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (reg_match(src, wr_en_m, wr_reg_m)) begin
      sel = FWD_MEM;
    end else if (reg_match(src, wr_en_w, wr_reg_w)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Pipeline <-> hazard unit signal bundle (master = pipeline side).
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_if;

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       branch_taken_d;
  logic       hilo_use_d;

  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] wr_reg_e;
  logic       reg_write_e;
  logic       mem_to_reg_e;
  logic       md_start_e;
  logic       md_is_div_e;

  logic [4:0] wr_reg_m;
  logic       reg_write_m;
  logic [4:0] wr_reg_w;
  logic       reg_write_w;

  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] fwd_a_e;
  logic [1:0] fwd_b_e;
  logic       md_busy;

  modport master (
    output rs_d, rt_d, branch_taken_d, hilo_use_d,
    output rs_e, rt_e, wr_reg_e, reg_write_e, mem_to_reg_e, md_start_e, md_is_div_e,
    output wr_reg_m, reg_write_m, wr_reg_w, reg_write_w,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, md_busy
  );

  modport slave (
    input  rs_d, rt_d, branch_taken_d, hilo_use_d,
    input  rs_e, rt_e, wr_reg_e, reg_write_e, mem_to_reg_e, md_start_e, md_is_div_e,
    input  wr_reg_m, reg_write_m, wr_reg_w, reg_write_w,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, md_busy
  );

endinterface
`default_nettype wire

// File: rtl/md_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_ctr
// Purpose  : Mult/div occupancy tracker: IDLE/BUSY FSM with a latency down-counter.
// Revision : 1.0
// ============================================================================
module md_busy_ctr
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;

  // Loading latency-1 and leaving on count 0 keeps the unit busy for exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == MD_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/flush/forward control. Define HAZARD_CTRL_FWD_EN to
//            resolve E-stage RAW hazards by forwarding instead of stalling.
// Revision : 1.0
// ============================================================================
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  logic       md_busy_raw;
  logic       load_use;
  logic       md_stall;
  logic       dep_stall;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  md_busy_ctr #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md_busy_ctr (
    .clk    (clk),
    .rst    (rst),
    .start  (hz.md_start_e),
    .is_div (hz.md_is_div_e),
    .busy   (md_busy_raw)
  );

  always_comb begin
    load_use = hz.mem_to_reg_e &&
               (reg_match(hz.rs_d, hz.reg_write_e, hz.wr_reg_e) ||
                reg_match(hz.rt_d, hz.reg_write_e, hz.wr_reg_e));
    md_stall = md_busy_raw && hz.hilo_use_d;
`ifdef HAZARD_CTRL_FWD_EN
    dep_stall = 1'b0;
    fwd_a     = fwd_sel(hz.rs_e, hz.reg_write_m, hz.wr_reg_m, hz.reg_write_w, hz.wr_reg_w);
    fwd_b     = fwd_sel(hz.rt_e, hz.reg_write_m, hz.wr_reg_m, hz.reg_write_w, hz.wr_reg_w);
`else
    // No bypass network: wait out producers in E and M; W is covered by write-first RF.
    dep_stall = reg_match(hz.rs_d, hz.reg_write_e, hz.wr_reg_e) ||
                reg_match(hz.rt_d, hz.reg_write_e, hz.wr_reg_e) ||
                reg_match(hz.rs_d, hz.reg_write_m, hz.wr_reg_m) ||
                reg_match(hz.rt_d, hz.reg_write_m, hz.wr_reg_m);
    fwd_a     = FWD_NONE;
    fwd_b     = FWD_NONE;
`endif
    stall = !rst && (load_use || md_stall || dep_stall);
  end

  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.flush_e = stall;
  assign hz.flush_d = !rst && hz.branch_taken_d && !stall;
  assign hz.fwd_a_e = rst ? FWD_NONE : fwd_a;
  assign hz.fwd_b_e = rst ? FWD_NONE : fwd_b;
  assign hz.md_busy = !rst && md_busy_raw;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed and random checks of hazard_ctrl against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam int DIV_CYCLES = 32;
  localparam int MUL_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int md_left     = 0;
  bit checking    = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles of the mult/div unit.
  always @(posedge clk) begin
    if (rst)                 md_left <= 0;
    else if (md_left > 0)    md_left <= md_left - 1;
    else if (bus.md_start_e) md_left <= bus.md_is_div_e ? DIV_CYCLES : MUL_CYCLES;
  end

  function automatic logic writes(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst != 0) && (dst == src);
  endfunction

  logic       m_busy, m_lu, m_dep, m_stall, m_flush_d;
  logic [1:0] m_fa, m_fb;
  logic [4:0] srcs [2];

  always @(negedge clk) begin
    if (checking) begin
      m_busy = !rst && (md_left > 0);
      srcs[0] = bus.rs_d;
      srcs[1] = bus.rt_d;
      m_lu  = 1'b0;
      m_dep = 1'b0;
      foreach (srcs[k]) begin
        if (bus.mem_to_reg_e && writes(bus.reg_write_e, bus.wr_reg_e, srcs[k])) m_lu = 1'b1;
`ifndef HAZARD_CTRL_FWD_EN
        if (writes(bus.reg_write_e, bus.wr_reg_e, srcs[k]) ||
            writes(bus.reg_write_m, bus.wr_reg_m, srcs[k])) m_dep = 1'b1;
`endif
      end
      m_stall   = !rst && (m_lu || (m_busy && bus.hilo_use_d) || m_dep);
      m_flush_d = !rst && bus.branch_taken_d && !m_stall;
      m_fa = 2'b00;
      m_fb = 2'b00;
`ifdef HAZARD_CTRL_FWD_EN
      if (!rst) begin
        if      (writes(bus.reg_write_m, bus.wr_reg_m, bus.rs_e)) m_fa = 2'b10;
        else if (writes(bus.reg_write_w, bus.wr_reg_w, bus.rs_e)) m_fa = 2'b01;
        if      (writes(bus.reg_write_m, bus.wr_reg_m, bus.rt_e)) m_fb = 2'b10;
        else if (writes(bus.reg_write_w, bus.wr_reg_w, bus.rt_e)) m_fb = 2'b01;
      end
`endif
      chk1("stall_f", bus.stall_f, m_stall);
      chk1("stall_d", bus.stall_d, m_stall);
      chk1("flush_e", bus.flush_e, m_stall);
      chk1("flush_d", bus.flush_d, m_flush_d);
      chk1("md_busy", bus.md_busy, m_busy);
      chk2("fwd_a_e", bus.fwd_a_e, m_fa);
      chk2("fwd_b_e", bus.fwd_b_e, m_fb);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_d = 0; bus.rt_d = 0; bus.branch_taken_d = 0; bus.hilo_use_d = 0;
    bus.rs_e = 0; bus.rt_e = 0; bus.wr_reg_e = 0; bus.reg_write_e = 0;
    bus.mem_to_reg_e = 0; bus.md_start_e = 0; bus.md_is_div_e = 0;
    bus.wr_reg_m = 0; bus.reg_write_m = 0; bus.wr_reg_w = 0; bus.reg_write_w = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    checking = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("rst_stall", bus.stall_d, 1'b0);
      chk1("rst_busy", bus.md_busy, 1'b0);
    end
    next_cycle();
    rst = 1'b0;

    // Load-use on rs_d, then the same with register 0 as destination.
    bus.mem_to_reg_e = 1; bus.reg_write_e = 1; bus.wr_reg_e = 5; bus.rs_d = 5;
    @(negedge clk);
    chk1("lu_stall_f", bus.stall_f, 1'b1);
    chk1("lu_stall_d", bus.stall_d, 1'b1);
    chk1("lu_flush_e", bus.flush_e, 1'b1);
    next_cycle();
    bus.wr_reg_e = 0;
    @(negedge clk);
    chk1("r0_stall_f", bus.stall_f, 1'b0);
    chk1("r0_flush_e", bus.flush_e, 1'b0);

    // Branch during a load-use stall is held off, then flushes.
    next_cycle();
    bus.wr_reg_e = 5; bus.branch_taken_d = 1;
    @(negedge clk);
    chk1("br_stall_flush_d", bus.flush_d, 1'b0);
    chk1("br_stall_stall_d", bus.stall_d, 1'b1);
    next_cycle();
    clear_inputs();
    bus.branch_taken_d = 1;
    @(negedge clk);
    chk1("br_flush_d", bus.flush_d, 1'b1);

    next_cycle();
    clear_inputs();
`ifdef HAZARD_CTRL_FWD_EN
    bus.rs_e = 7; bus.wr_reg_m = 7; bus.wr_reg_w = 7; bus.reg_write_m = 1; bus.reg_write_w = 1;
    @(negedge clk);
    chk2("fwd_mem", bus.fwd_a_e, 2'b10);
    next_cycle();
    bus.reg_write_m = 0;
    @(negedge clk);
    chk2("fwd_wb", bus.fwd_a_e, 2'b01);
`else
    bus.rs_d = 3; bus.wr_reg_m = 3; bus.reg_write_m = 1;
    @(negedge clk);
    chk1("dep_m_stall", bus.stall_d, 1'b1);
    chk2("dep_m_fwd_a", bus.fwd_a_e, 2'b00);
    chk2("dep_m_fwd_b", bus.fwd_b_e, 2'b00);
`endif

    // Divide: busy exactly 32 cycles; a start while busy must not reload.
    next_cycle();
    clear_inputs();
    bus.hilo_use_d = 1; bus.md_start_e = 1; bus.md_is_div_e = 1;
    @(negedge clk);
    chk1("div_issue_busy", bus.md_busy, 1'b0);
    next_cycle();
    bus.md_start_e = 0;
    for (int i = 0; i < DIV_CYCLES; i++) begin
      @(negedge clk);
      chk1("div_busy", bus.md_busy, 1'b1);
      chk1("div_stall", bus.stall_d, 1'b1);
      next_cycle();
      bus.md_start_e  = (i == 4);
      bus.md_is_div_e = 0;
    end
    @(negedge clk);
    chk1("div_done_busy", bus.md_busy, 1'b0);
    chk1("div_done_stall", bus.stall_d, 1'b0);

    // Reset on the 10th busy cycle aborts the divide; a mult then runs 4 cycles.
    next_cycle();
    clear_inputs();
    bus.md_start_e = 1; bus.md_is_div_e = 1;
    next_cycle();
    bus.md_start_e = 0;
    repeat (9) begin
      @(negedge clk);
      chk1("abort_pre_busy", bus.md_busy, 1'b1);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk1("abort_rst_busy", bus.md_busy, 1'b0);
    next_cycle();
    rst = 1'b0;
    bus.md_start_e = 1; bus.md_is_div_e = 0;
    @(negedge clk);
    chk1("abort_after_busy", bus.md_busy, 1'b0);
    next_cycle();
    bus.md_start_e = 0;
    repeat (MUL_CYCLES) begin
      @(negedge clk);
      chk1("mul_busy", bus.md_busy, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk1("mul_done_busy", bus.md_busy, 1'b0);

    // Random traffic over a small register range so matches are frequent.
    repeat (3000) begin
      next_cycle();
      rst                = ($urandom_range(0, 99) == 0);
      bus.rs_d           = 5'($urandom_range(0, 3));
      bus.rt_d           = 5'($urandom_range(0, 3));
      bus.branch_taken_d = 1'($urandom_range(0, 1));
      bus.hilo_use_d     = 1'($urandom_range(0, 1));
      bus.rs_e           = 5'($urandom_range(0, 3));
      bus.rt_e           = 5'($urandom_range(0, 3));
      bus.wr_reg_e       = 5'($urandom_range(0, 3));
      bus.reg_write_e    = 1'($urandom_range(0, 1));
      bus.mem_to_reg_e   = 1'($urandom_range(0, 1));
      bus.md_start_e     = ($urandom_range(0, 7) == 0);
      bus.md_is_div_e    = 1'($urandom_range(0, 1));
      bus.wr_reg_m       = 5'($urandom_range(0, 3));
      bus.reg_write_m    = 1'($urandom_range(0, 1));
      bus.wr_reg_w       = 5'($urandom_range(0, 3));
      bus.reg_write_w    = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning divide latency in cycles (>=2).
REQ-002 SHALL have parameter MUL_CYCLES, default 4, meaning multiply latency in cycles (>=2).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have these decode-stage inputs: rs_d, rt_d  in  5 each  D-stage source registers; branch_taken_d  in  1  control transfer resolved in D; hilo_use_d  in  1  D instruction reads HI/LO or is mult/div.
REQ-005 SHALL have these execute-stage inputs: rs_e, rt_e, wr_reg_e  in  5 each; reg_write_e  in  1; mem_to_reg_e  in  1  load in E; md_start_e  in  1  mult/div issues; md_is_div_e  in  1  1=div, 0=mult.
REQ-006 SHALL have these later-stage inputs: wr_reg_m  in  5; reg_write_m  in  1; wr_reg_w  in  5; reg_write_w  in  1.
REQ-007 SHALL have these outputs: stall_f, stall_d  out  1 each  hold PC / D register; flush_d, flush_e  out  1 each  clear input of D/E pipeline registers; fwd_a_e, fwd_b_e  out  2 each  E-operand source select; md_busy  out  1  mult/div unit busy.

Function
REQ-008 SHALL compute all outputs combinationally from the inputs and the registered mult/div state, so they are valid in the same cycle.
REQ-009 SHALL detect a load-use hazard when mem_to_reg_e & reg_write_e & wr_reg_e!=0 & (wr_reg_e==rs_d | wr_reg_e==rt_d).
REQ-010 On a load-use hazard, stall_f=stall_d=flush_e=1.
REQ-011 SHALL assert flush_d = branch_taken_d & ~stall_d, so a stall suppresses the branch flush.
REQ-012 SHALL implement a mult/div FSM with states IDLE and BUSY and a down-counter of width clog2(max(DIV_CYCLES,MUL_CYCLES)).
REQ-013 In IDLE, md_start_e=1 SHALL go to BUSY on the next edge and load the counter with DIV_CYCLES-1 if md_is_div_e, else MUL_CYCLES-1.
REQ-014 In BUSY, the counter SHALL decrement each cycle; when the counter is 0 it SHALL return to IDLE on the next edge.
REQ-015 md_start_e in BUSY SHALL be ignored, with no counter reload.
REQ-016 md_busy SHALL be 1 exactly in BUSY, so a DIV_CYCLES=32 divide reads busy for 32 cycles.
REQ-017 In BUSY with hilo_use_d=1, stall_f=stall_d=flush_e=1.
REQ-018 Load-use and mult/div stalls SHALL OR together; simultaneous sources produce a single stall, not a priority conflict.
REQ-019 Register 0 SHALL never cause a hazard or a forward.

Reset
REQ-020 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter to 0.
REQ-021 While rst=1, stall_f, stall_d, flush_d, flush_e and md_busy SHALL be 0 and fwd_a_e/fwd_b_e SHALL be 2'b00.
REQ-022 Reset mid-operation SHALL abort any mult/div in progress, with no completion pulse.

Configuration
REQ-023 Macro HAZARD_CTRL_FWD_EN, when defined, SHALL set fwd_a_e=2'b10 if reg_write_m & wr_reg_m!=0 & wr_reg_m==rs_e.
REQ-024 Otherwise fwd_a_e SHALL be 2'b01 if the same condition holds for W; otherwise 2'b00. M has priority over W. fwd_b_e is identical using rt_e.
REQ-025 Without the macro, fwd_a_e and fwd_b_e SHALL be tied 2'b00.
REQ-026 Without the macro, stall_f=stall_d=flush_e=1 whenever rs_d or rt_d (nonzero) matches a written wr_reg_e or wr_reg_m. W needs no stall because of the write-first register file.

Structure
REQ-027 The shared package mips_pkg SHALL hold the forward-select constants FWD_NONE=00, FWD_WB=01, FWD_MEM=10 and the md_state_t enum {MD_IDLE, MD_BUSY}.
REQ-028 The mult/div FSM and counter SHALL be sub-module md_busy_ctr (ports clk, rst, start, is_div, busy); the hazard logic stays in hazard_ctrl.

Verification
REQ-029 Load in E with wr_reg_e=5, rs_d=5 -> stall_f=stall_d=flush_e=1 for that cycle; with wr_reg_e=0 -> all 0.
REQ-030 md_start_e=1, md_is_div_e=1 for one cycle -> md_busy=1 for exactly 32 cycles; hilo_use_d=1 throughout -> stalls for those 32 cycles, cleared on the 33rd.
REQ-031 With FWD_EN, wr_reg_m=wr_reg_w=7, both writing, rs_e=7 -> fwd_a_e=10; with reg_write_m=0 -> fwd_a_e=01.
REQ-032 branch_taken_d=1 with a concurrent load-use hazard -> flush_d=0 and stall_d=1; the next cycle, with no hazard -> flush_d=1.
REQ-033 rst=1 on the 10th BUSY cycle of a divide -> md_busy=0 on the next cycle; a new mult then gives md_busy for 4 cycles.
REQ-034 Without FWD_EN, rs_d=3 with wr_reg_m=3 writing -> stall asserted and fwd outputs 00.
